// File: rtl/dec_to_bin.sv
// Signed BCD to two's-complement converter using reverse double-dabble.
// One bit is shifted out of the BCD register per cycle; start/busy/done handshake.
module dec_to_bin #(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [3:0]            signal,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      binary,
    output logic                  error
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BCD_W + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [3:0]       SIGN_NEG   = 4'b1010;
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BCD_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]       state;
    logic [BCD_W-1:0] bcd_reg;
    logic [BCD_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             neg;
    logic             err;

    logic [BCD_W-1:0] bcd_sh;
    logic [BCD_W-1:0] bcd_nxt;
    logic [BCD_W-1:0] acc_nxt;

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] d);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Magnitude is zero-extended before negation so the full word carries the sign.
    function automatic logic [WIDTH-1:0] signed_result(
        input logic [BCD_W-1:0] mag_in,
        input logic             is_neg,
        input logic             is_err
    );
        logic signed [WIDTH-1:0] mag;
        logic signed [WIDTH-1:0] res;
        mag = signed'({{(WIDTH-BCD_W){1'b0}}, mag_in});
        res = is_neg ? -mag : mag;
        return is_err ? '0 : $unsigned(res);
    endfunction

    // One reverse double-dabble step: shift right, then correct each BCD nibble.
    always_comb begin
        {bcd_sh, acc_nxt} = {bcd_reg, acc} >> 1;
        bcd_nxt = bcd_sh;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sh[4*i +: 4] >= 4'd8) begin
                bcd_nxt[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            bcd_reg <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            binary  <= '0;
            error   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bcd_reg <= digits;
                        neg     <= (signal == SIGN_NEG);
                        err     <= has_bad_digit(digits);
                        acc     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_reg <= bcd_nxt;
                    acc     <= acc_nxt;
                    cnt     <= cnt + CNT_ONE;
                    if (cnt == LAST_SHIFT) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    binary <= signed_result(acc, neg, err);
                    error  <= err;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_to_bin.sv
// Scoreboard bench for dec_to_bin: expected results are queued at start and
// compared when done pulses; latency, busy length and reset abort are also checked.
module tb_dec_to_bin;

    localparam logic [3:0] NEG = 4'b1010;

    typedef struct packed {
        logic [31:0] bin;
        logic        err;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [11:0] digits;
    logic [3:0]  signal;
    logic        busy;
    logic        done;
    logic [31:0] binary;
    logic        error;

    int   checks;
    int   failures;
    int   done_count;
    exp_t exp_q[$];

    dec_to_bin #(.DIGITS(3), .WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .digits  (digits),
        .signal  (signal),
        .busy    (busy),
        .done    (done),
        .binary  (binary),
        .error   (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [11:0] d, input logic [3:0] s);
        exp_t        e;
        int          val;
        int          scale;
        logic [3:0]  nib;
        e.err = 1'b0;
        val   = 0;
        scale = 1;
        for (int i = 0; i < 3; i++) begin
            nib = d[4*i +: 4];
            if (nib > 4'd9) e.err = 1'b1;
            val   = val + int'(nib) * scale;
            scale = scale * 10;
        end
        if (e.err) e.bin = 32'd0;
        else if (s == NEG) e.bin = 32'(-val);
        else e.bin = 32'(val);
        return e;
    endfunction

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n && done) begin
            exp_t e;
            done_count++;
            if (exp_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("binary", binary, e.bin);
                chk("error", error, e.err);
            end
        end
    end

    task automatic drive_start(input logic [11:0] d, input logic [3:0] s);
        digits = d;
        signal = s;
        start  = 1'b1;
        exp_q.push_back(model(d, s));
    endtask

    task automatic wait_done(input bit chk_timing);
        int cyc;
        int bcnt;
        bit seen;
        cyc  = 0;
        bcnt = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clock);
            start = 1'b0;
            cyc++;
            if (done) seen = 1'b1;
            else if (busy) bcnt++;
        end
        chk("done_seen", seen, 1);
        if (chk_timing) begin
            chk("latency", cyc, 14);
            chk("busy_cycles", bcnt, 13);
        end
    endtask

    task automatic run_conv(input logic [11:0] d, input logic [3:0] s, input bit chk_timing);
        @(negedge clock);
        drive_start(d, s);
        wait_done(chk_timing);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int  cyc;
        bit  seen;
        checks     = 0;
        failures   = 0;
        done_count = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        digits     = '0;
        signal     = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_binary", binary, 0);
        chk("rst_error", error, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_no_done", done_count, 0);

        run_conv(12'h123, 4'h0, 1'b1);
        run_conv(12'h999, NEG, 1'b1);
        chk("neg999_const", binary, 32'hFFFF_FC19);
        run_conv(12'h000, NEG, 1'b0);
        run_conv(12'h100, 4'h0, 1'b0);
        run_conv(12'h1A5, 4'h0, 1'b1);
        chk("bad_digit_flag", error, 1);
        run_conv(12'h005, 4'h0, 1'b0);
        run_conv(12'h870, NEG, 1'b0);
        run_conv(12'h9F0, NEG, 1'b0);

        // Outputs hold between conversions.
        repeat (5) @(negedge clock);
        chk("hold_binary", binary, 0);
        chk("hold_error", error, 1);

        // Start held high with digits changing; then a back-to-back start.
        @(negedge clock);
        drive_start(12'h123, 4'h0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clock);
            cyc++;
            digits = (cyc % 2 == 1) ? 12'h777 : 12'h456;
            signal = (cyc % 2 == 1) ? NEG : 4'h0;
            if (done) seen = 1'b1;
        end
        chk("held_done_seen", seen, 1);
        chk("held_latency", cyc, 14);
        drive_start(12'h250, NEG);
        wait_done(1'b1);

        // Reset in the middle of a conversion abandons it.
        @(negedge clock);
        drive_start(12'h321, 4'h0);
        repeat (6) @(negedge clock);
        start = 1'b0;
        chk("pre_abort_busy", busy, 1);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_binary", binary, 0);
        repeat (2) @(negedge clock);
        reset_n    = 1'b1;
        done_count = 0;
        repeat (20) @(negedge clock);
        chk("abort_no_done", done_count, 0);
        run_conv(12'h042, 4'h0, 1'b1);

        repeat (3) @(negedge clock);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
